// File: rtl/program_loader.sv
// program_loader: boot loader turning a UART byte stream (4-byte LE length header, then LE words) into instruction RAM writes, then releasing the core and reporting ACK/ERR/END bytes.
// Ports: clk, rstn (async active-high reset); rx_data/rx_valid byte input; tx_data/tx_valid/tx_ready byte output;
//        wr_en_instr/data_in_instr/addr_in_instr RAM write port; core_start release level; core_end termination level; busy load in progress.
module program_loader #(
  parameter int unsigned MAX_WORDS = 16384,
  parameter int unsigned ADDR_INC  = 4,
  parameter logic [7:0]  ACK_BYTE  = 8'hAA,
  parameter logic [7:0]  ERR_BYTE  = 8'hEE,
  parameter logic [7:0]  END_BYTE  = 8'h55
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tx_ready,
  input  logic        core_end,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        wr_en_instr,
  output logic [31:0] data_in_instr,
  output logic [31:0] addr_in_instr,
  output logic        core_start,
  output logic        busy
);
  typedef enum logic [2:0] {HDR, DATA, SEND_ACK, SEND_ERR, RUN, SEND_END, DONE} state_t;
  state_t      state;
  logic [1:0]  idx;
  logic [23:0] lo;
  logic [31:0] len, cnt;
  logic        take;
  logic [31:0] word;
  assign take = rx_valid && (state == HDR || state == DATA);
  // lo shifts bytes in from the top, so after three bytes it holds them little-endian
  assign word = {rx_data, lo};
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state         <= HDR;
      idx           <= '0;
      lo            <= '0;
      len           <= '0;
      cnt           <= '0;
      tx_data       <= '0;
      tx_valid      <= 1'b0;
      wr_en_instr   <= 1'b0;
      data_in_instr <= '0;
      addr_in_instr <= '0;
      core_start    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      wr_en_instr <= 1'b0;
      if (take) begin
        lo  <= {rx_data, lo[23:8]};
        idx <= idx + 2'd1;
      end
      case (state)
        HDR: if (take) begin
          busy <= 1'b1;
          if (idx == 2'd3) begin
            len <= word;
            if (word > MAX_WORDS) begin
              state    <= SEND_ERR;
              tx_valid <= 1'b1;
              tx_data  <= ERR_BYTE;
            end else if (word == '0) begin
              state    <= SEND_ACK;
              tx_valid <= 1'b1;
              tx_data  <= ACK_BYTE;
            end else begin
              state         <= DATA;
              addr_in_instr <= '0;
              cnt           <= '0;
            end
          end
        end
        DATA: begin
          if (take && idx == 2'd3) begin
            wr_en_instr   <= 1'b1;
            data_in_instr <= word;
          end
          // address/count advance in the cycle following the write strobe
          if (wr_en_instr) begin
            addr_in_instr <= addr_in_instr + ADDR_INC;
            cnt           <= cnt + 32'd1;
            if (cnt + 32'd1 == len) begin
              state    <= SEND_ACK;
              tx_valid <= 1'b1;
              tx_data  <= ACK_BYTE;
            end
          end
        end
        SEND_ACK: if (tx_ready) begin
          tx_valid   <= 1'b0;
          core_start <= 1'b1;
          busy       <= 1'b0;
          state      <= RUN;
        end
        SEND_ERR: if (tx_ready) begin
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          idx      <= '0;
          len      <= '0;
          state    <= HDR;
        end
        RUN: if (core_end) begin
          state    <= SEND_END;
          tx_valid <= 1'b1;
          tx_data  <= END_BYTE;
        end
        SEND_END: if (tx_ready) begin
          tx_valid <= 1'b0;
          state    <= DONE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: self-checking bench for program_loader driven by directed byte streams against a stream-level model.
module tb_program_loader;
  typedef logic [7:0] byte_q_t[$];
  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b1;
  logic        core_end = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        wr_en_instr;
  logic [31:0] data_in_instr;
  logic [31:0] addr_in_instr;
  logic        core_start;
  logic        busy;
  int checks = 0;
  int errors = 0;
  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  bit         exp_start = 0;
  bit         start_next = 0;
  bit         active = 0;
  bit         prev_v = 0;
  bit         prev_acc = 0;
  logic [7:0] prev_d = '0;

  program_loader dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid), .tx_ready(tx_ready),
    .core_end(core_end), .tx_data(tx_data), .tx_valid(tx_valid), .wr_en_instr(wr_en_instr),
    .data_in_instr(data_in_instr), .addr_in_instr(addr_in_instr), .core_start(core_start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Expected RAM writes and tx bytes derived from a complete header+payload stream
  function automatic void expect_load(input byte_q_t q);
    logic [31:0] l;
    l = {q[3], q[2], q[1], q[0]};
    if (l > 32'd16384) begin
      exp_tx.push_back(8'hEE);
      return;
    end
    for (int i = 0; i < int'(l); i++)
      exp_wr.push_back('{a: 32'(4 * i), d: {q[4*i+7], q[4*i+6], q[4*i+5], q[4*i+4]}});
    exp_tx.push_back(8'hAA);
  endfunction

  always @(negedge clk) begin
    if (active && !rstn) begin
      if (start_next) exp_start = 1;
      start_next = 0;
      if (wr_en_instr) begin
        if (exp_wr.size() == 0) chk("unexpected_write", addr_in_instr, 32'hFFFFFFFF);
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("write_addr", addr_in_instr, e.a);
          chk("write_data", data_in_instr, e.d);
        end
      end
      if (prev_v && !prev_acc) begin
        chk("tx_valid_held", 32'(tx_valid), 32'd1);
        chk("tx_data_stable", 32'(tx_data), 32'(prev_d));
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) chk("unexpected_tx", 32'(tx_data), 32'h100);
        else begin
          logic [7:0] e;
          e = exp_tx.pop_front();
          chk("tx_byte", 32'(tx_data), 32'(e));
          if (e == 8'hAA) start_next = 1;
        end
      end
      chk("core_start", 32'(core_start), 32'(exp_start));
      prev_v = tx_valid;
      prev_acc = tx_ready;
      prev_d = tx_data;
    end
  end

  task automatic check_zero();
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_wr_en", 32'(wr_en_instr), 32'd0);
    chk("rst_data", data_in_instr, 32'd0);
    chk("rst_addr", addr_in_instr, 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    #1;
    check_zero();
    exp_wr.delete();
    exp_tx.delete();
    exp_start = 0;
    start_next = 0;
    prev_v = 0;
    @(posedge clk); #1;
    rstn = 1'b0;
    active = 1;
  endtask

  task automatic send_bytes(input byte_q_t q, input bit b2b);
    foreach (q[i]) begin
      rx_data = q[i];
      rx_valid = 1'b1;
      @(posedge clk); #1;
      if (!b2b) begin
        rx_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    rx_valid = 1'b0;
    if (b2b) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && (exp_wr.size() + exp_tx.size()) != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain", 32'(exp_wr.size() + exp_tx.size()), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    byte_q_t s;
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end

  initial begin
    byte_q_t s;
    // two-word load with idle gaps
    do_reset();
    s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    expect_load(s);
    send_bytes(s[0:0], 0);
    chk("busy_first_byte", 32'(busy), 32'd1);
    send_bytes(s[1:$], 0);
    wait_idle(50);
    chk("l1_last_data", data_in_instr, 32'h00100093);
    chk("l1_final_addr", addr_in_instr, 32'd8);
    chk("l1_core_start", 32'(core_start), 32'd1);
    chk("l1_busy", 32'(busy), 32'd0);
    // core_end held high: exactly one END byte
    exp_tx.push_back(8'h55);
    core_end = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    core_end = 1'b0;
    wait_idle(20);
    chk("end_tx_valid", 32'(tx_valid), 32'd0);
    chk("end_core_start", 32'(core_start), 32'd1);
    // back-to-back three-word load
    do_reset();
    s = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
          8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h73, 8'h00, 8'h00, 8'h00};
    expect_load(s);
    send_bytes(s, 1);
    wait_idle(50);
    chk("b2b_last_data", data_in_instr, 32'h00000073);
    chk("b2b_final_addr", addr_in_instr, 32'd12);
    // oversize header rejected, then a valid one-word load
    do_reset();
    s = '{8'h01, 8'h40, 8'h00, 8'h00};
    expect_load(s);
    send_bytes(s, 0);
    wait_idle(20);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_tx_valid", 32'(tx_valid), 32'd0);
    s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h02, 8'h00, 8'h40};
    expect_load(s);
    send_bytes(s, 0);
    wait_idle(50);
    chk("reload_data", data_in_instr, 32'h400002B7);
    chk("reload_addr", addr_in_instr, 32'd4);
    // header exactly at capacity is accepted (no ERR, stays busy)
    do_reset();
    s = '{8'h00, 8'h40, 8'h00, 8'h00};
    send_bytes(s, 0);
    repeat (5) begin @(posedge clk); #1; end
    chk("max_no_tx", 32'(tx_valid), 32'd0);
    chk("max_busy", 32'(busy), 32'd1);
    // zero-length load with ACK stalled by tx_ready; early core_end ignored
    do_reset();
    tx_ready = 1'b0;
    core_end = 1'b1;
    s = '{8'h00, 8'h00, 8'h00, 8'h00};
    expect_load(s);
    send_bytes(s, 0);
    for (int i = 0; i < 10; i++) begin
      chk("stall_tx_valid", 32'(tx_valid), 32'd1);
      chk("stall_tx_data", 32'(tx_data), 32'hAA);
      chk("stall_core_start", 32'(core_start), 32'd0);
      @(posedge clk); #1;
    end
    core_end = 1'b0;
    tx_ready = 1'b1;
    wait_idle(20);
    chk("zero_core_start", 32'(core_start), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    // reset mid-word abandons the load; next load restarts at address 0
    do_reset();
    s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00};
    send_bytes(s, 0);
    do_reset();
    s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h37, 8'h12, 8'h00, 8'h00};
    expect_load(s);
    send_bytes(s, 0);
    wait_idle(50);
    chk("post_rst_data", data_in_instr, 32'h00001237);
    chk("post_rst_addr", addr_in_instr, 32'd4);
    chk("post_rst_start", 32'(core_start), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
